memory_access_stage: RTL and testbench

- MEM stage of the 5-stage MIPS pipeline; consumes the EX/MEM control and data bundle.
- Holds the word-organised data memory and performs byte, halfword and word loads and stores with sign or zero extension.
- Resolves conditional branches toward IF.
- Registers the MEM/WB bundle for the write-back stage.
- Provides a debug read port to the debug unit.
- Contains a RUN/HALTED state machine that freezes memory side effects once a halt instruction retires through MEM.

---
 rtl/memory_access_stage.sv | 181 ++++++++++++++++++
 tb/tb_memory_access_stage.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_access_stage.sv
// rtl/memory_access_stage.sv - MIPS MEM stage: data memory, branch resolve, MEM/WB register, halt FSM
// Little-endian word memory with byte/half/word access; a retired halt freezes stores and bubbles WB.
module memory_access_stage #(
  parameter int NB_DATA     = 32,
  parameter int NB_REGISTER = 5,
  parameter int NB_ADDR     = 7
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_valid,
  input  logic                   i_flush,
  input  logic                   i_branch,
  input  logic [1:0]             i_jump,
  input  logic                   i_mem_read,
  input  logic                   i_mem_write,
  input  logic                   i_mem_to_reg,
  input  logic                   i_reg_write,
  input  logic                   i_halt,
  input  logic [NB_DATA-1:0]     i_pc_4,
  input  logic [NB_DATA-1:0]     i_pc_branch,
  input  logic [NB_DATA-1:0]     i_alu_result,
  input  logic [NB_DATA-1:0]     i_read_data_2,
  input  logic [NB_REGISTER:0]   i_opcode,
  input  logic [NB_REGISTER-1:0] i_rt_rd,
  input  logic                   i_zero,
  input  logic [NB_ADDR-1:0]     i_dbg_addr,
  output logic                   o_pc_src,
  output logic [NB_DATA-1:0]     o_pc_branch,
  output logic                   o_reg_write,
  output logic                   o_mem_to_reg,
  output logic                   o_halt,
  output logic [1:0]             o_jump,
  output logic [NB_DATA-1:0]     o_read_data,
  output logic [NB_DATA-1:0]     o_alu_result,
  output logic [NB_DATA-1:0]     o_pc_4,
  output logic [NB_REGISTER-1:0] o_rt_rd,
  output logic                   o_misaligned,
  output logic                   o_halted,
  output logic [NB_DATA-1:0]     o_dbg_data
);

  localparam logic [NB_REGISTER:0] OP_LB  = (NB_REGISTER+1)'(6'b100000);
  localparam logic [NB_REGISTER:0] OP_LH  = (NB_REGISTER+1)'(6'b100001);
  localparam logic [NB_REGISTER:0] OP_LBU = (NB_REGISTER+1)'(6'b100100);
  localparam logic [NB_REGISTER:0] OP_LHU = (NB_REGISTER+1)'(6'b100101);
  localparam logic [NB_REGISTER:0] OP_SB  = (NB_REGISTER+1)'(6'b101000);
  localparam logic [NB_REGISTER:0] OP_SH  = (NB_REGISTER+1)'(6'b101001);
  localparam logic [NB_REGISTER:0] OP_BNE = (NB_REGISTER+1)'(6'b000101);

  typedef enum logic {RUN, HALTED} state_t;

  state_t             state, state_next;
  logic [NB_DATA-1:0] mem [2**NB_ADDR];

  logic               act, mem_access, is_byte, is_half, is_signed, misaligned, store_en;
  logic [NB_ADDR-1:0] word_idx;
  logic [1:0]         lane;
  logic [NB_DATA-1:0] rd_word, load_data, wr_data;
  logic [15:0]        rd_shift;
  logic [3:0]         byte_en;
  logic               unused_addr_bits;

  assign act        = i_valid & ~i_flush & (state == RUN);
  assign word_idx   = i_alu_result[NB_ADDR+1:2];
  assign lane       = i_alu_result[1:0];
  assign mem_access = i_mem_read | i_mem_write;
  assign rd_word    = mem[word_idx];
  assign unused_addr_bits = ^i_alu_result[NB_DATA-1:NB_ADDR+2];

  always_comb begin
    is_byte   = 1'b0;
    is_half   = 1'b0;
    is_signed = 1'b1;
    case (i_opcode)
      OP_LB, OP_SB: is_byte = 1'b1;
      OP_LBU: begin
        is_byte   = 1'b1;
        is_signed = 1'b0;
      end
      OP_LH, OP_SH: is_half = 1'b1;
      OP_LHU: begin
        is_half   = 1'b1;
        is_signed = 1'b0;
      end
      default: ;
    endcase
  end

  // Anything that is neither byte nor half is a word access.
  assign misaligned = mem_access & (is_half ? lane[0] : (~is_byte & (lane != 2'b00)));
  assign store_en   = act & i_mem_write & ~misaligned;

  // For aligned halves lane*8 equals addr[1]*16, so one shifter serves both widths.
  assign rd_shift = 16'(rd_word >> {lane, 3'b000});

  always_comb begin
    load_data = '0;
    if (i_mem_read && !misaligned) begin
      if (is_byte)
        load_data = {{(NB_DATA-8){is_signed & rd_shift[7]}}, rd_shift[7:0]};
      else if (is_half)
        load_data = {{(NB_DATA-16){is_signed & rd_shift[15]}}, rd_shift[15:0]};
      else
        load_data = rd_word;
    end
  end

  always_comb begin
    byte_en = 4'b1111;
    wr_data = i_read_data_2;
    if (is_byte) begin
      byte_en = 4'b0001 << lane;
      wr_data = {4{i_read_data_2[7:0]}};
    end else if (is_half) begin
      byte_en = lane[1] ? 4'b1100 : 4'b0011;
      wr_data = {2{i_read_data_2[15:0]}};
    end
  end

  always_ff @(posedge i_clock) begin
    for (int b = 0; b < 4; b++) begin
      if (store_en && byte_en[b])
        mem[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
    end
  end

  assign o_pc_src    = act & i_branch & ((i_opcode == OP_BNE) ? ~i_zero : i_zero);
  assign o_pc_branch = i_pc_branch;
  assign o_halted    = (state == HALTED);

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) state <= RUN;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (act && i_halt) state_next = HALTED;
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      o_reg_write  <= 1'b0;
      o_mem_to_reg <= 1'b0;
      o_halt       <= 1'b0;
      o_jump       <= '0;
      o_read_data  <= '0;
      o_alu_result <= '0;
      o_pc_4       <= '0;
      o_rt_rd      <= '0;
      o_misaligned <= 1'b0;
      o_dbg_data   <= '0;
    end else begin
      o_dbg_data <= mem[i_dbg_addr];
      if (i_valid) begin
        if (act) begin
          o_reg_write  <= i_reg_write;
          o_mem_to_reg <= i_mem_to_reg;
          o_halt       <= i_halt;
          o_jump       <= i_jump;
          o_read_data  <= load_data;
          o_alu_result <= i_alu_result;
          o_pc_4       <= i_pc_4;
          o_rt_rd      <= i_rt_rd;
          o_misaligned <= misaligned;
        end else begin
          o_reg_write  <= 1'b0;
          o_mem_to_reg <= 1'b0;
          o_halt       <= 1'b0;
          o_jump       <= '0;
          o_read_data  <= '0;
          o_alu_result <= '0;
          o_pc_4       <= '0;
          o_rt_rd      <= '0;
          o_misaligned <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_memory_access_stage.sv
// tb/tb_memory_access_stage.sv - self-checking bench for memory_access_stage
// Byte-array reference memory; directed scenarios followed by a randomized run.
module tb_memory_access_stage;

  localparam int NB_DATA     = 32;
  localparam int NB_REGISTER = 5;
  localparam int NB_ADDR     = 7;
  localparam int MEM_BYTES   = 4 * (2**NB_ADDR);

  localparam logic [5:0] LB = 6'b100000, LH = 6'b100001, LW = 6'b100011, LBU = 6'b100100;
  localparam logic [5:0] LHU = 6'b100101, LWU = 6'b100111, SB = 6'b101000, SH = 6'b101001;
  localparam logic [5:0] SW = 6'b101011, BEQ = 6'b000100, BNE = 6'b000101;

  logic clk = 1'b0, rst_n = 1'b0;
  logic valid, flush, branch, mem_read, mem_write, mem_to_reg, reg_write, halt, zero;
  logic [1:0]  jump;
  logic [31:0] pc_4, pc_branch, alu_result, read_data_2;
  logic [5:0]  opcode;
  logic [4:0]  rt_rd;
  logic [6:0]  dbg_addr;

  logic        pc_src, o_reg_write, o_mem_to_reg, o_halt, o_misaligned, o_halted;
  logic [1:0]  o_jump;
  logic [31:0] o_pc_branch, o_read_data, o_alu_result, o_pc_4, o_dbg_data;
  logic [4:0]  o_rt_rd;

  int checks = 0, failures = 0;
  byte unsigned ref_mem [MEM_BYTES];
  bit ref_halted = 1'b0;

  memory_access_stage #(.NB_DATA(NB_DATA), .NB_REGISTER(NB_REGISTER), .NB_ADDR(NB_ADDR)) dut (
    .i_clock(clk), .i_reset(rst_n), .i_valid(valid), .i_flush(flush), .i_branch(branch),
    .i_jump(jump), .i_mem_read(mem_read), .i_mem_write(mem_write), .i_mem_to_reg(mem_to_reg),
    .i_reg_write(reg_write), .i_halt(halt), .i_pc_4(pc_4), .i_pc_branch(pc_branch),
    .i_alu_result(alu_result), .i_read_data_2(read_data_2), .i_opcode(opcode), .i_rt_rd(rt_rd),
    .i_zero(zero), .i_dbg_addr(dbg_addr), .o_pc_src(pc_src), .o_pc_branch(o_pc_branch),
    .o_reg_write(o_reg_write), .o_mem_to_reg(o_mem_to_reg), .o_halt(o_halt), .o_jump(o_jump),
    .o_read_data(o_read_data), .o_alu_result(o_alu_result), .o_pc_4(o_pc_4), .o_rt_rd(o_rt_rd),
    .o_misaligned(o_misaligned), .o_halted(o_halted), .o_dbg_data(o_dbg_data)
  );

  always #5 clk = ~clk;

  function automatic int acc_size(input logic [5:0] op);
    case (op)
      LB, SB, LBU: return 1;
      LH, SH, LHU: return 2;
      default:     return 4;
    endcase
  endfunction

  function automatic bit is_mis(input logic [5:0] op, input logic [31:0] addr);
    return (addr % acc_size(op)) != 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [5:0] op, input logic [31:0] addr);
    int unsigned base = addr % MEM_BYTES;
    logic [31:0] v = 0;
    if (is_mis(op, addr)) return 32'h0;
    for (int i = 0; i < acc_size(op); i++) v = v | (32'(ref_mem[base + i]) << (8 * i));
    if (op == LB && v[7])  v = v | 32'hFFFF_FF00;
    if (op == LH && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  function automatic logic [31:0] ref_word(input int idx);
    return {ref_mem[4*idx+3], ref_mem[4*idx+2], ref_mem[4*idx+1], ref_mem[4*idx]};
  endfunction

  task automatic ref_store(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] data);
    int unsigned base = addr % MEM_BYTES;
    for (int i = 0; i < acc_size(op); i++) ref_mem[base + i] = 8'(data >> (8 * i));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    valid = 1'b1; flush = 1'b0; branch = 1'b0; jump = 2'b00; mem_read = 1'b0;
    mem_write = 1'b0; mem_to_reg = 1'b0; reg_write = 1'b0; halt = 1'b0; zero = 1'b0;
    pc_4 = 32'h0; pc_branch = 32'h0; alu_result = 32'h0; read_data_2 = 32'h0;
    opcode = 6'h0; rt_rd = 5'h0;
  endtask

  task automatic set_mem(input bit rd, input bit wr, input logic [5:0] op,
                         input logic [31:0] addr, input logic [31:0] data);
    set_idle();
    mem_read = rd; mem_write = wr; mem_to_reg = rd; reg_write = rd;
    opcode = op; alu_result = addr; read_data_2 = data; rt_rd = 5'd9;
  endtask

  // Issues one memory instruction for a cycle and keeps the reference memory in step.
  task automatic do_mem(input bit rd, input bit wr, input logic [5:0] op, input logic [31:0] addr,
                        input logic [31:0] data, output logic [31:0] exp_ld);
    set_mem(rd, wr, op, addr, data);
    exp_ld = rd ? ref_load(op, addr) : 32'h0;
    tick();
    if (wr && !is_mis(op, addr) && !ref_halted) ref_store(op, addr, data);
  endtask

  task automatic test_reset();
    set_idle();
    dbg_addr = 7'd0;
    #2;
    checks++; if (o_read_data !== 32'h0) begin failures++; $display("FAIL reset_read_data got=%h exp=0", o_read_data); end
    checks++; if ({o_reg_write, o_mem_to_reg, o_halt, o_jump, o_misaligned, o_halted} !== 7'b0) begin
      failures++; $display("FAIL reset_ctrl got=%b exp=0", {o_reg_write, o_mem_to_reg, o_halt, o_jump, o_misaligned, o_halted}); end
    checks++; if ({o_alu_result, o_pc_4, o_rt_rd, o_dbg_data} !== 101'b0) begin
      failures++; $display("FAIL reset_data got=%h exp=0", {o_alu_result, o_pc_4, o_rt_rd, o_dbg_data}); end
    tick();
    checks++; if (o_dbg_data !== 32'h0 || pc_src !== 1'b0) begin
      failures++; $display("FAIL reset_held got=%h/%b exp=0/0", o_dbg_data, pc_src); end
    rst_n = 1'b1;
  endtask

  task automatic fill_memory();
    logic [31:0] ld;
    for (int i = 0; i < 2**NB_ADDR; i++) do_mem(1'b0, 1'b1, SW, 32'(4 * i), $urandom, ld);
  endtask

  task automatic test_store_load();
    logic [31:0] ld;
    dbg_addr = 7'd4;
    do_mem(1'b0, 1'b1, SW, 32'h10, 32'hDEADBEEF, ld);
    do_mem(1'b1, 1'b0, LW, 32'h10, 32'h0, ld);
    checks++; if (o_read_data !== 32'hDEADBEEF) begin failures++; $display("FAIL sw_lw got=%h exp=deadbeef", o_read_data); end
    checks++; if (o_dbg_data !== 32'hDEADBEEF) begin failures++; $display("FAIL dbg_read got=%h exp=deadbeef", o_dbg_data); end
    checks++; if (o_reg_write !== 1'b1 || o_mem_to_reg !== 1'b1 || o_rt_rd !== 5'd9 || o_alu_result !== 32'h10) begin
      failures++; $display("FAIL lw_wb_ctrl got=%b%b/%0d/%h exp=11/9/10", o_reg_write, o_mem_to_reg, o_rt_rd, o_alu_result); end
  endtask

  task automatic test_extend();
    logic [31:0] ld;
    logic [5:0]  ops   [4] = '{LB, LBU, LH, LHU};
    logic [31:0] addrs [4] = '{32'h23, 32'h23, 32'h22, 32'h20};
    logic [31:0] exps  [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h00007F01};
    do_mem(1'b0, 1'b1, SW, 32'h20, 32'h80FF7F01, ld);
    for (int i = 0; i < 4; i++) begin
      do_mem(1'b1, 1'b0, ops[i], addrs[i], 32'h0, ld);
      checks++; if (o_read_data !== exps[i]) begin
        failures++; $display("FAIL extend_%0d got=%h exp=%h", i, o_read_data, exps[i]); end
      checks++; if (o_misaligned !== 1'b0) begin failures++; $display("FAIL extend_mis_%0d got=%b exp=0", i, o_misaligned); end
    end
  endtask

  task automatic test_partial_store();
    logic [31:0] ld;
    do_mem(1'b0, 1'b1, SW, 32'h20, 32'h11223344, ld);
    do_mem(1'b0, 1'b1, SB, 32'h21, 32'h123456AA, ld);
    do_mem(1'b1, 1'b0, LW, 32'h20, 32'h0, ld);
    checks++; if (o_read_data !== 32'h1122AA44) begin failures++; $display("FAIL sb_merge got=%h exp=1122aa44", o_read_data); end
    do_mem(1'b0, 1'b1, SH, 32'h23, 32'h00005555, ld);
    checks++; if (o_misaligned !== 1'b1) begin failures++; $display("FAIL sh_misaligned got=%b exp=1", o_misaligned); end
    do_mem(1'b1, 1'b0, LW, 32'h20, 32'h0, ld);
    checks++; if (o_read_data !== 32'h1122AA44 || o_misaligned !== 1'b0) begin
      failures++; $display("FAIL sh_nowrite got=%h/%b exp=1122aa44/0", o_read_data, o_misaligned); end
    do_mem(1'b1, 1'b0, LW, 32'h22, 32'h0, ld);
    checks++; if (o_read_data !== 32'h0 || o_misaligned !== 1'b1) begin
      failures++; $display("FAIL lw_misaligned got=%h/%b exp=0/1", o_read_data, o_misaligned); end
  endtask

  task automatic test_branch();
    set_idle();
    branch = 1'b1; opcode = BEQ; zero = 1'b1; pc_branch = 32'h0000_1234; reg_write = 1'b1; rt_rd = 5'd3;
    #1;
    checks++; if (pc_src !== 1'b1 || o_pc_branch !== 32'h1234) begin
      failures++; $display("FAIL beq_taken got=%b/%h exp=1/1234", pc_src, o_pc_branch); end
    tick();
    checks++; if (o_reg_write !== 1'b1) begin failures++; $display("FAIL beq_wb got=%b exp=1", o_reg_write); end
    opcode = BNE;
    #1;
    checks++; if (pc_src !== 1'b0) begin failures++; $display("FAIL bne_not_taken got=%b exp=0", pc_src); end
    opcode = BEQ; flush = 1'b1;
    #1;
    checks++; if (pc_src !== 1'b0) begin failures++; $display("FAIL beq_flush got=%b exp=0", pc_src); end
    tick();
    checks++; if (o_reg_write !== 1'b0 || o_rt_rd !== 5'd0) begin
      failures++; $display("FAIL flush_bubble got=%b/%0d exp=0/0", o_reg_write, o_rt_rd); end
  endtask

  task automatic test_wrap_hold();
    logic [31:0] ld;
    dbg_addr = 7'd1;
    do_mem(1'b0, 1'b1, SW, 32'h204, 32'hCAFEF00D, ld);
    do_mem(1'b1, 1'b0, LW, 32'h204, 32'h0, ld);
    checks++; if (o_dbg_data !== 32'hCAFEF00D || o_read_data !== 32'hCAFEF00D) begin
      failures++; $display("FAIL addr_wrap got=%h/%h exp=cafef00d", o_dbg_data, o_read_data); end
    set_mem(1'b0, 1'b1, SW, 32'h4, 32'h0);
    valid = 1'b0; pc_4 = 32'h44;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (o_read_data !== 32'hCAFEF00D || o_alu_result !== 32'h204) begin
        failures++; $display("FAIL hold_data_%0d got=%h/%h exp=cafef00d/204", c, o_read_data, o_alu_result); end
      checks++; if (o_reg_write !== 1'b1 || o_rt_rd !== 5'd9 || o_pc_4 !== 32'h0) begin
        failures++; $display("FAIL hold_ctrl_%0d got=%b/%0d/%h exp=1/9/0", c, o_reg_write, o_rt_rd, o_pc_4); end
    end
    checks++; if (o_dbg_data !== 32'hCAFEF00D) begin failures++; $display("FAIL hold_nowrite got=%h exp=cafef00d", o_dbg_data); end
  endtask

  task automatic test_random();
    logic [5:0]  ops [12] = '{LB, LH, LW, LBU, LHU, LWU, SB, SH, SW, 6'b000000, 6'b001000, 6'b110011};
    logic [31:0] e_rd, e_alu, e_pc4, e_dbg;
    logic [4:0]  e_rt;
    logic [1:0]  e_jump;
    logic        e_rw, e_m2r, e_mis, e_pcs;
    bit          act;
    e_rd = 0; e_alu = 0; e_pc4 = 0; e_rt = 0; e_jump = 0; e_rw = 0; e_m2r = 0; e_mis = 0;
    for (int n = 0; n < 400; n++) begin
      set_idle();
      opcode = ops[$urandom_range(0, 11)];
      mem_read  = (opcode[5:3] == 3'b100) || (opcode == 6'b110011 && $urandom_range(0, 1) == 1);
      mem_write = (opcode[5:3] == 3'b101);
      valid = (n == 0) || ($urandom_range(0, 7) != 0);
      flush = ($urandom_range(0, 9) == 0);
      alu_result = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 3) == 0) alu_result = alu_result | ($urandom & 32'hFFFF_FE00) | 32'($urandom_range(0, 511));
      read_data_2 = $urandom; pc_4 = $urandom; pc_branch = $urandom; rt_rd = 5'($urandom);
      jump = 2'($urandom); reg_write = 1'($urandom); mem_to_reg = mem_read;
      branch = 1'($urandom); zero = 1'($urandom);
      if (branch && $urandom_range(0, 1) == 1) opcode = $urandom_range(0, 1) ? BEQ : BNE;
      dbg_addr = 7'($urandom);
      act = valid && !flush && !ref_halted;
      e_pcs = act && branch && ((opcode == BNE) ? !zero : zero);
      #1;
      checks++; if (pc_src !== e_pcs) begin failures++; $display("FAIL rnd_pc_src n=%0d got=%b exp=%b", n, pc_src, e_pcs); end
      e_dbg = ref_word(int'(dbg_addr));
      if (valid) begin
        if (act) begin
          e_rd = mem_read ? ref_load(opcode, alu_result) : 32'h0;
          e_mis = (mem_read || mem_write) && is_mis(opcode, alu_result);
          e_alu = alu_result; e_pc4 = pc_4; e_rt = rt_rd; e_jump = jump; e_rw = reg_write; e_m2r = mem_to_reg;
        end else begin
          e_rd = 0; e_mis = 0; e_alu = 0; e_pc4 = 0; e_rt = 0; e_jump = 0; e_rw = 0; e_m2r = 0;
        end
      end
      tick();
      if (act && mem_write && !is_mis(opcode, alu_result)) ref_store(opcode, alu_result, read_data_2);
      checks++; if (o_read_data !== e_rd || o_misaligned !== e_mis) begin
        failures++; $display("FAIL rnd_load n=%0d got=%h/%b exp=%h/%b", n, o_read_data, o_misaligned, e_rd, e_mis); end
      checks++; if (o_alu_result !== e_alu || o_pc_4 !== e_pc4 || o_rt_rd !== e_rt) begin
        failures++; $display("FAIL rnd_data n=%0d got=%h/%h/%0d exp=%h/%h/%0d", n, o_alu_result, o_pc_4, o_rt_rd, e_alu, e_pc4, e_rt); end
      checks++; if ({o_jump, o_reg_write, o_mem_to_reg, o_halt} !== {e_jump, e_rw, e_m2r, 1'b0}) begin
        failures++; $display("FAIL rnd_ctrl n=%0d got=%b exp=%b", n, {o_jump, o_reg_write, o_mem_to_reg, o_halt}, {e_jump, e_rw, e_m2r, 1'b0}); end
      checks++; if (o_dbg_data !== e_dbg) begin failures++; $display("FAIL rnd_dbg n=%0d got=%h exp=%h", n, o_dbg_data, e_dbg); end
    end
  endtask

  task automatic test_halt_reset();
    logic [31:0] ld, old_word;
    set_idle();
    halt = 1'b1;
    tick();
    ref_halted = 1'b1;
    checks++; if (o_halted !== 1'b1 || o_halt !== 1'b1) begin
      failures++; $display("FAIL halt_enter got=%b/%b exp=1/1", o_halted, o_halt); end
    dbg_addr = 7'd16;
    old_word = ref_word(16);
    do_mem(1'b0, 1'b1, SW, 32'h40, ~old_word, ld);
    reg_write = 1'b1; mem_write = 1'b0;
    tick();
    checks++; if (o_dbg_data !== old_word) begin failures++; $display("FAIL halt_store_blocked got=%h exp=%h", o_dbg_data, old_word); end
    checks++; if (o_reg_write !== 1'b0 || o_halt !== 1'b0 || o_halted !== 1'b1) begin
      failures++; $display("FAIL halt_bubble got=%b/%b/%b exp=0/0/1", o_reg_write, o_halt, o_halted); end
    set_idle(); branch = 1'b1; opcode = BEQ; zero = 1'b1;
    #1;
    checks++; if (pc_src !== 1'b0) begin failures++; $display("FAIL halt_branch got=%b exp=0", pc_src); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (o_halted !== 1'b0 || o_dbg_data !== 32'h0 || o_alu_result !== 32'h0) begin
      failures++; $display("FAIL async_reset got=%b/%h/%h exp=0/0/0", o_halted, o_dbg_data, o_alu_result); end
    ref_halted = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    do_mem(1'b1, 1'b0, LW, 32'h40, 32'h0, ld);
    checks++; if (o_read_data !== old_word || o_reg_write !== 1'b1) begin
      failures++; $display("FAIL mem_kept_after_reset got=%h/%b exp=%h/1", o_read_data, o_reg_write, old_word); end
  endtask

  initial begin
    test_reset();
    fill_memory();
    test_store_load();
    test_extend();
    test_partial_store();
    test_branch();
    test_wrap_hold();
    test_random();
    test_halt_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
